// File: rtl/jtag_types_pkg.sv
// Shared AHB and AP-master types for the debug access path.
// Holds bus encodings, master FSM states and the alignment helper.
package jtag_types_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } ahb_htrans_t;

    typedef enum logic [2:0] {
        SIZE_BYTE  = 3'd0,
        SIZE_HALF  = 3'd1,
        SIZE_WORD  = 3'd2,
        SIZE_DWORD = 3'd3
    } ahb_size_t;

    typedef enum logic [1:0] {
        MST_IDLE,
        MST_ADDR,
        MST_DATA,
        MST_ERR
    } ahb_mst_state_t;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    function automatic logic is_misaligned(
        input logic [1:0] size,
        input logic [1:0] lsb
    );
        logic r;
        r = 1'b0;
        if (size == 2'd1) r = lsb[0];
        if (size == 2'd2) r = (lsb != 2'b00);
        return r;
    endfunction

endpackage

// File: rtl/ahb_ap_master_addr_gen.sv
// Address register for the AP master: load, post-increment and
// alignment check against the address the next transfer will use.
module ahb_addr_gen
    import jtag_types_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              inc_en,
    input  logic [4:0]        inc,
    input  logic [1:0]        chk_size,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] eff_addr,
    output logic              misaligned
);

    logic [ADDR_W-1:0] addr_q;

    // A same-cycle load is visible to the transfer it accompanies
    assign eff_addr   = load ? load_addr : addr_q;
    assign misaligned = is_misaligned(chk_size, eff_addr[1:0]);
    assign addr       = addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
        end else if (load) begin
            addr_q <= load_addr;
        end else if (inc_en) begin
            addr_q <= addr_q + ADDR_W'(inc);
        end
    end

endmodule

// File: rtl/ahb_ap_master.sv
// AP-to-AHB-Lite master: one SINGLE transfer per AP command.
// Optional HREADY watchdog enabled by defining AHB_AP_TIMEOUT_EN.
module ahb_ap_master
    import jtag_types_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              AFT_CLK,
    input  logic              TRST,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              xfer_start,
    input  logic              xfer_write,
    input  logic [1:0]        xfer_size,
    input  logic [4:0]        xfer_inc,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic              err_clr,
    output logic              busy,
    output logic [DATA_W-1:0] rdata_out,
    output logic              rdata_valid,
    output logic              err,
    output logic [ADDR_W-1:0] addr_out,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);

    ahb_mst_state_t state_q, state_d;

    logic              write_q;
    logic [1:0]        size_q;
    logic [4:0]        inc_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;
    logic              err_q;

    logic              idle;
    logic              accept;
    logic              complete;
    logic              set_err;
    logic              tmo;
    logic              misaligned;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] eff_addr;

    assign idle   = (state_q == MST_IDLE);
    assign accept = idle && xfer_start;

    ahb_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk        (AFT_CLK),
        .rst        (TRST),
        .load       (addr_load && idle),
        .load_addr  (addr_in),
        .inc_en     (complete),
        .inc        (inc_q),
        .chk_size   (xfer_size),
        .addr       (addr_q),
        .eff_addr   (eff_addr),
        .misaligned (misaligned)
    );

`ifdef AHB_AP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt;

    always_ff @(posedge AFT_CLK or posedge TRST) begin
        if (TRST) begin
            tmo_cnt <= '0;
        end else if (idle || HREADY || tmo) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    // Fires on the TIMEOUT_CYCLES-th consecutive HREADY-low cycle
    assign tmo = !idle && !HREADY &&
                 (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
    assign tmo = 1'b0;
`endif

    always_ff @(posedge AFT_CLK or posedge TRST) begin
        if (TRST) state_q <= MST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        complete = 1'b0;
        set_err  = 1'b0;
        unique case (state_q)
            MST_IDLE: begin
                if (xfer_start) begin
                    if (xfer_size == 2'd3 || misaligned) set_err = 1'b1;
                    else                                 state_d = MST_ADDR;
                end
            end
            MST_ADDR: begin
                if (HREADY) state_d = MST_DATA;
            end
            MST_DATA: begin
                if (HREADY) begin
                    state_d = MST_IDLE;
                    if (HRESP == HRESP_OKAY) complete = 1'b1;
                    else                     set_err  = 1'b1;
                end else if (HRESP == HRESP_ERROR) begin
                    state_d = MST_ERR;
                end
            end
            MST_ERR: begin
                if (HREADY) begin
                    state_d = MST_IDLE;
                    set_err = 1'b1;
                end
            end
            default: state_d = MST_IDLE;
        endcase
        if (tmo) begin
            state_d  = MST_IDLE;
            complete = 1'b0;
            set_err  = 1'b1;
        end
    end

    always_ff @(posedge AFT_CLK or posedge TRST) begin
        if (TRST) begin
            write_q  <= 1'b0;
            size_q   <= 2'd0;
            inc_q    <= 5'd0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                write_q <= xfer_write;
                size_q  <= xfer_size;
                inc_q   <= xfer_inc;
                wdata_q <= wdata_in;
            end
            if (complete && !write_q) rdata_q <= HRDATA;
            rvalid_q <= complete && !write_q;
            // A new error wins over a simultaneous clear
            if (set_err)      err_q <= 1'b1;
            else if (err_clr) err_q <= 1'b0;
        end
    end

    assign busy        = !idle;
    assign rdata_out   = rdata_q;
    assign rdata_valid = rvalid_q;
    assign err         = err_q;
    assign addr_out    = addr_q;

    assign HADDR  = addr_q;
    assign HTRANS = (state_q == MST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HWRITE = (state_q == MST_ADDR) && write_q;
    assign HSIZE  = (state_q == MST_ADDR) ? {1'b0, size_q} : 3'd0;
    assign HBURST = HBURST_SINGLE;
    assign HWDATA = wdata_q;

    // eff_addr equals addr_q outside the accept cycle; kept for clarity
    logic unused_eff;
    assign unused_eff = ^eff_addr;

endmodule

// File: tb/tb_ahb_ap_master.sv
// Self-checking bench for ahb_ap_master: directed table, TRST
// sequences, optional timeout and randomized transfers vs a model.
module tb_ahb_ap_master;

    logic        AFT_CLK = 1'b0;
    logic        TRST;
    logic        addr_load;
    logic [31:0] addr_in;
    logic        xfer_start;
    logic        xfer_write;
    logic [1:0]  xfer_size;
    logic [4:0]  xfer_inc;
    logic [31:0] wdata_in;
    logic        err_clr;
    logic        busy;
    logic [31:0] rdata_out;
    logic        rdata_valid;
    logic        err;
    logic [31:0] addr_out;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    ahb_ap_master #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)
    ) dut (
        .AFT_CLK(AFT_CLK), .TRST(TRST),
        .addr_load(addr_load), .addr_in(addr_in),
        .xfer_start(xfer_start), .xfer_write(xfer_write),
        .xfer_size(xfer_size), .xfer_inc(xfer_inc),
        .wdata_in(wdata_in), .err_clr(err_clr),
        .busy(busy), .rdata_out(rdata_out),
        .rdata_valid(rdata_valid), .err(err),
        .addr_out(addr_out), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
        .HRESP(HRESP)
    );

    always #5 AFT_CLK = ~AFT_CLK;

    typedef struct {
        logic        clr;
        logic        clr_same;
        logic        load;
        logic [31:0] laddr;
        logic        wr;
        logic [1:0]  size;
        logic [4:0]  inc;
        logic [31:0] wdata;
        int          aws;
        int          ws;
        logic        rerr;
        logic [31:0] rdat;
        logic        mid;
    } xfer_t;

    typedef struct {
        xfer_t       x;
        logic [31:0] exp_addr;
        logic        exp_err;
        int          exp_valid;
        logic [31:0] exp_rdata;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_addr;
    logic        m_err;
    logic [31:0] m_rdata;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic xfer_t mkx(
        logic clr, logic clr_same, logic load, logic [31:0] laddr,
        logic wr, logic [1:0] size, logic [4:0] inc, logic [31:0] wdata,
        int aws, int ws, logic rerr, logic [31:0] rdat, logic mid);
        xfer_t x;
        x.clr = clr; x.clr_same = clr_same; x.load = load;
        x.laddr = laddr; x.wr = wr; x.size = size; x.inc = inc;
        x.wdata = wdata; x.aws = aws; x.ws = ws; x.rerr = rerr;
        x.rdat = rdat; x.mid = mid;
        return x;
    endfunction

    task automatic do_reset();
        TRST = 1'b1;
        addr_load = 0; addr_in = 0; xfer_start = 0; xfer_write = 0;
        xfer_size = 0; xfer_inc = 0; wdata_in = 0; err_clr = 0;
        HRDATA = 0; HREADY = 1; HRESP = 0;
        repeat (2) @(posedge AFT_CLK);
        #1 TRST = 1'b0;
        m_addr = 0; m_err = 0; m_rdata = 0;
    endtask

    // Runs one AP command with a small AHB slave model; returns valid pulses
    task automatic run_xfer(input xfer_t v, output int nvalid);
        logic [31:0] eff;
        logic        bad;
        int nonseq, acyc, dcyc, cyc, exp_cyc;
        if (v.clr) begin
            err_clr = 1;
            @(posedge AFT_CLK); #1;
            err_clr = 0;
            m_err = 0;
        end
        eff = v.load ? v.laddr : m_addr;
        bad = (v.size == 2'd3) ||
              (v.size == 2'd1 && eff[0]) ||
              (v.size == 2'd2 && eff[1:0] != 2'b00);
        addr_load = v.load; addr_in = v.laddr;
        xfer_start = 1; xfer_write = v.wr; xfer_size = v.size;
        xfer_inc = v.inc; wdata_in = v.wdata; err_clr = v.clr_same;
        HREADY = 1; HRESP = 0;
        @(posedge AFT_CLK); #1;
        addr_load = 0; xfer_start = 0; err_clr = 0;
        wdata_in = ~v.wdata;
        if (v.clr_same) m_err = 0;
        chk("busy_after_start", busy, !bad);
        chk("htrans_after_start", HTRANS, bad ? 2'b00 : 2'b10);
        nonseq = 0; acyc = 0; dcyc = 0; cyc = 0; nvalid = 0;
        while (busy && cyc < 200) begin
            if (v.mid && cyc == 0) begin
                addr_load = 1; addr_in = 32'hBAD0_0000; xfer_start = 1;
            end else begin
                addr_load = 0; xfer_start = 0;
            end
            if (HTRANS == 2'b10) begin
                nonseq++;
                if (nonseq == 1) begin
                    chk("haddr", HADDR, eff);
                    chk("hwrite", HWRITE, v.wr);
                    chk("hsize", HSIZE, {1'b0, v.size});
                end
                HREADY = (acyc >= v.aws); HRESP = 0;
                acyc++;
            end else begin
                if (v.wr && dcyc == 0) chk("hwdata", HWDATA, v.wdata);
                if (dcyc < v.ws) begin
                    HREADY = 0; HRESP = 0;
                end else if (v.rerr) begin
                    HRESP = 1; HREADY = (dcyc > v.ws);
                end else begin
                    HREADY = 1; HRESP = 0; HRDATA = v.rdat;
                end
                dcyc++;
            end
            @(posedge AFT_CLK); #1;
            cyc++;
            if (rdata_valid) nvalid++;
        end
        addr_load = 0; xfer_start = 0;
        HREADY = 1; HRESP = 0; HRDATA = $urandom;
        if (busy) chk("xfer_timeout", busy, 1'b0);
        @(posedge AFT_CLK); #1;
        if (rdata_valid) nvalid++;

        exp_cyc = bad ? 0 : 2 + v.aws + v.ws + (v.rerr ? 1 : 0);
        chk("latency", cyc, exp_cyc);
        chk("nonseq_cycles", nonseq, bad ? 0 : v.aws + 1);
        if (bad || v.rerr) begin
            m_err = 1; m_addr = eff;
        end else begin
            m_addr = eff + {27'd0, v.inc};
            if (!v.wr) m_rdata = v.rdat;
        end
        chk("rvalid_count", nvalid, (!bad && !v.rerr && !v.wr) ? 1 : 0);
        chk("addr_out", addr_out, m_addr);
        chk("err", err, m_err);
        chk("rdata_out", rdata_out, m_rdata);
        chk("htrans_idle", HTRANS, 2'b00);
    endtask

    vec_t tbl[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        xfer_t x;

        tbl[0] = '{mkx(0,0,1,32'h2000_0000,1,2,4,32'hDEAD_BEEF,0,0,0,0,0),
                   32'h2000_0004, 0, 0, 32'h0};
        tbl[1] = '{mkx(0,0,0,0,0,2,4,0,0,3,0,32'h1234_5678,0),
                   32'h2000_0008, 0, 1, 32'h1234_5678};
        tbl[2] = '{mkx(0,0,0,0,0,2,4,0,0,0,1,32'hFFFF_FFFF,0),
                   32'h2000_0008, 1, 0, 32'h1234_5678};
        tbl[3] = '{mkx(1,0,0,0,1,0,1,32'h55,0,0,0,0,0),
                   32'h2000_0009, 0, 0, 32'h1234_5678};
        tbl[4] = '{mkx(0,1,0,0,0,3,4,0,0,0,0,0,0),
                   32'h2000_0009, 1, 0, 32'h1234_5678};
        tbl[5] = '{mkx(1,0,1,32'h0000_0101,0,1,2,0,0,0,0,0,0),
                   32'h0000_0101, 1, 0, 32'h1234_5678};
        tbl[6] = '{mkx(1,0,1,32'hFFFF_FFFC,1,2,4,32'h0BAD_F00D,0,0,0,0,0),
                   32'h0000_0000, 0, 0, 32'h1234_5678};
        tbl[7] = '{mkx(0,0,0,0,0,1,2,0,2,1,0,32'h0000_A5A5,1),
                   32'h0000_0002, 0, 1, 32'h0000_A5A5};
        tbl[8] = '{mkx(0,0,0,0,0,2,0,0,0,0,0,0,0),
                   32'h0000_0002, 1, 0, 32'h0000_A5A5};
        tbl[9] = '{mkx(1,0,0,0,1,0,0,32'h77,0,2,0,0,0),
                   32'h0000_0002, 0, 0, 32'h0000_A5A5};

        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_rdata", rdata_out, 0);
        chk("rst_rvalid", rdata_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_addr", addr_out, 0);
        chk("rst_haddr", HADDR, 0);
        chk("rst_htrans", HTRANS, 0);
        chk("rst_hwrite", HWRITE, 0);
        chk("rst_hsize", HSIZE, 0);
        chk("rst_hburst", HBURST, 0);
        chk("rst_hwdata", HWDATA, 0);

        for (int i = 0; i < 10; i++) begin
            run_xfer(tbl[i].x, nv);
            chk($sformatf("tbl%0d_addr", i), addr_out, tbl[i].exp_addr);
            chk($sformatf("tbl%0d_err", i), err, tbl[i].exp_err);
            chk($sformatf("tbl%0d_valid", i), nv, tbl[i].exp_valid);
            chk($sformatf("tbl%0d_rdata", i), rdata_out, tbl[i].exp_rdata);
        end

        // TRST while the address phase is stalled
        addr_load = 1; addr_in = 32'h4000_0000;
        xfer_start = 1; xfer_write = 0; xfer_size = 2; xfer_inc = 4;
        @(posedge AFT_CLK); #1;
        addr_load = 0; xfer_start = 0; HREADY = 0;
        chk("trst_a_pre", HTRANS, 2'b10);
        #2 TRST = 1;
        #1;
        chk("trst_a_htrans", HTRANS, 2'b00);
        chk("trst_a_busy", busy, 0);
        chk("trst_a_addr", addr_out, 0);
        chk("trst_a_err", err, 0);
        @(posedge AFT_CLK); #1;
        TRST = 0; HREADY = 1;
        m_addr = 0; m_err = 0; m_rdata = 0;

        // TRST while in the data phase
        xfer_start = 1; xfer_write = 0; xfer_size = 2; xfer_inc = 4;
        @(posedge AFT_CLK); #1;
        xfer_start = 0;
        @(posedge AFT_CLK); #1;
        HREADY = 0;
        chk("trst_d_pre", busy, 1);
        #2 TRST = 1;
        #1;
        chk("trst_d_busy", busy, 0);
        chk("trst_d_htrans", HTRANS, 2'b00);
        @(posedge AFT_CLK); #1;
        TRST = 0; HREADY = 1;

`ifdef AHB_AP_TIMEOUT_EN
        begin
            int cyc;
            addr_load = 1; addr_in = 32'h0000_0100;
            xfer_start = 1; xfer_write = 0; xfer_size = 2; xfer_inc = 4;
            @(posedge AFT_CLK); #1;
            addr_load = 0; xfer_start = 0; HREADY = 0;
            cyc = 0;
            while (busy && cyc < 40) begin
                @(posedge AFT_CLK); #1;
                cyc++;
            end
            HREADY = 1;
            chk("tmo_cycles", cyc, 8);
            chk("tmo_err", err, 1);
            chk("tmo_addr", addr_out, 32'h0000_0100);
            m_addr = 32'h0000_0100; m_err = 1;
        end
`endif

        for (int i = 0; i < 60; i++) begin
            x.clr = ($urandom_range(0, 3) == 0);
            x.clr_same = ($urandom_range(0, 7) == 0);
            x.load = $urandom_range(0, 1);
            x.laddr = $urandom;
            if ($urandom_range(0, 9) < 7) x.laddr[1:0] = 2'b00;
            x.wr = $urandom_range(0, 1);
            x.size = 2'($urandom_range(0, 6) % 4);
            x.inc = 5'($urandom_range(0, 31));
            x.wdata = $urandom;
            x.aws = $urandom_range(0, 2);
            x.ws = $urandom_range(0, 3);
            x.rerr = ($urandom_range(0, 5) == 0);
            x.rdat = $urandom;
            x.mid = ($urandom_range(0, 3) == 0);
            run_xfer(x, nv);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_ap_master.md
Name: ahb_ap_master

Overview:
- Bus-side stage directly downstream of the AHB access point.
- Takes decoded AP commands (address load, single read/write with size and post-increment) and executes each as one AHB-Lite SINGLE transfer.
- Returns read data, busy and a sticky error to the AP.
- Sits between the AP and the SoC AHB-Lite interconnect; one outstanding transfer at a time.

Parameters:
ADDR_W, 32, HADDR and address register width
DATA_W, 32, HWDATA/HRDATA width
TIMEOUT_CYCLES, 256, max HREADY-low cycles per transfer (used only under the optional feature)

Ports:
AFT_CLK  in  1  block clock; all state updates on rising edge
TRST  in  1  asynchronous active-high reset
addr_load  in  1  one-cycle pulse: load address register from addr_in
addr_in  in  ADDR_W  new base address
xfer_start  in  1  one-cycle pulse: begin a transfer; ignored while busy
xfer_write  in  1  0 = read, 1 = write
xfer_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
xfer_inc  in  5  byte post-increment applied after a successful transfer (0 = none)
wdata_in  in  DATA_W  write data, sampled with xfer_start
err_clr  in  1  clears sticky err
busy  out  1  high from the cycle after an accepted xfer_start until completion
rdata_out  out  DATA_W  last read data; holds value until next read completes
rdata_valid  out  1  one-cycle pulse when a read completes OKAY
err  out  1  sticky error flag
addr_out  out  ADDR_W  current address register
HADDR  out  ADDR_W  AHB address
HTRANS  out  2  IDLE = 00 or NONSEQ = 10 only
HWRITE  out  1  AHB write
HSIZE  out  3  {1'b0, xfer_size}
HBURST  out  3  constant 000 (SINGLE)
HWDATA  out  DATA_W  AHB write data
HRDATA  in  DATA_W  AHB read data
HREADY  in  1  AHB ready
HRESP  in  1  0 = OKAY, 1 = ERROR

Behaviour:
Reset values:
- All outputs 0; address register 0; state IDLE.
- TRST asserted mid-transfer forces HTRANS = IDLE immediately (asynchronous), drops busy, and discards the transfer.

State machine, states IDLE, ADDR, DATA, ERR:
- IDLE: on xfer_start, latch write, size, inc and wdata.
  - If size is 3, or the address is misaligned (half: addr[0] set; word: addr[1:0] nonzero), set err, issue no bus cycle, stay IDLE, busy stays 0.
  - Otherwise go to ADDR.
- ADDR: drive HTRANS = NONSEQ with HADDR, HWRITE and HSIZE. On HREADY = 1 go to DATA; otherwise hold all signals.
- DATA:
  - HTRANS = IDLE and HWDATA = latched wdata.
  - HREADY = 1 and HRESP = 0: completion. For a read, capture HRDATA into rdata_out and pulse rdata_valid. Add xfer_inc to the address register (mod 2^ADDR_W wrap). Go to IDLE.
  - HRESP = 1 and HREADY = 0: go to ERR.
- ERR: wait for HREADY = 1 (second cycle of the error response), then set err, leave the address unchanged, and go to IDLE.

Rules:
- busy = 1 in ADDR, DATA and ERR. Latency from xfer_start to completion, zero wait states: 3 cycles.
- addr_load and xfer_start in the same cycle: load first; the transfer uses addr_in.
- addr_load while busy is ignored.
- err_clr together with a new error: err ends set.
- HADDR is only meaningful while HTRANS = NONSEQ; it is held to the address register otherwise.

Optional Feature:
AHB_AP_TIMEOUT_EN:
- Defined: a counter runs while in ADDR, DATA or ERR with HREADY = 0 and clears on HREADY = 1. When it reaches TIMEOUT_CYCLES, abort to IDLE, set err, and do not increment the address.
- Undefined: the counter is absent and the block waits indefinitely.

Decomposition:
- jtag_types_pkg gains:
  - ahb_htrans_t (IDLE, BUSY, NONSEQ, SEQ)
  - ahb_size_t
  - the master state enum
  - HBURST_SINGLE and HRESP_OKAY/HRESP_ERROR constants
- One sub-module, ahb_addr_gen: holds the address register, applies load and post-increment, and produces the misalignment flag.

Test Plan:
- Word write, zero wait: addr_load 0x2000_0000; xfer_start write, size 2, inc 4, wdata 0xDEADBEEF. Expect HTRANS NONSEQ for 1 cycle, HWDATA 0xDEADBEEF in the next cycle, addr_out 0x2000_0004, err 0.
- Read with 3 wait states: HRDATA 0x1234_5678 driven with HREADY low for 3 data-phase cycles. Expect busy held, one rdata_valid pulse, rdata_out 0x1234_5678.
- Error response: HRESP = 1 for two cycles (HREADY 0 then 1). Expect err = 1, addr_out unchanged, no rdata_valid; err_clr then returns err to 0.
- Illegal and misaligned requests: size 3, and size 1 at 0x101. Expect no NONSEQ on the bus, err = 1, busy never asserted.
- Wrap and same-cycle load: addr_load 0xFFFF_FFFC with xfer_start, inc 4. Expect HADDR 0xFFFF_FFFC, then addr_out 0x0000_0000.
- TRST mid-DATA: HTRANS goes IDLE and busy goes 0 asynchronously. With AHB_AP_TIMEOUT_EN and TIMEOUT_CYCLES = 8, HREADY held low gives abort and err after 8 cycles.
